// File: rtl/texture_rom_arbiter_if.sv
// rtl/texture_rom_arbiter_if.sv - requester, response and ROM bus bundle for texture_rom_arbiter
//
// Purpose: groups the per-requester handshake, the response strobes and the
// ROM address/data pair so the arbiter and its users share one port.
// Signals:
//   req_valid [NUM_REQ]        per-requester read request
//   req_addr  [NUM_REQ*ADDR_W] packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready [NUM_REQ]        one-hot grant, combinational
//   rom_addr  [ADDR_W]         registered ROM address
//   rom_q     [DATA_W]         ROM read data
//   rsp_valid [NUM_REQ]        registered one-hot response strobe
//   rsp_data  [DATA_W]         registered ROM word for the strobed requester
// Modports: slave = arbiter side, master = requesters plus ROM side.
interface texture_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_addr, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/texture_rom_arbiter.sv
// rtl/texture_rom_arbiter.sv - shares one texture ROM between pixel-pipeline requesters
//
// Purpose: requester 0 (scan-out) normally wins; requesters 1..NUM_REQ-1 are
// served round-robin, and a starvation counter forces one of them through
// after STARVE_MAX consecutive losses to requester 0. One ROM read per cycle;
// a ROM_LAT-deep tag pipeline steers each returned word to its requester.
// Ports:
//   vga_clk      pixel clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse, resets rr pointer and starvation counter
//   bus          texture_rom_arbiter_if.slave (request/grant, ROM, response)
module texture_rom_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input logic                  vga_clk,
  input logic                  reset_n,
  input logic                  frame_start,
  texture_rom_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starve;
  logic [NUM_REQ-1:0] low_valid;
  logic [NUM_REQ-1:0] rr_hi;
  logic [NUM_REQ-1:0] rr_src;
  logic [NUM_REQ-1:0] rr_pick;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic               any_low;
  logic               gnt_low;

  logic [ADDR_W-1:0]  rom_addr_q;
  logic [ROM_LAT-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [ROM_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;

  assign starve    = (starve_cnt == CNT_W'(STARVE_MAX));
  assign low_valid = {bus.req_valid[NUM_REQ-1:1], 1'b0};
  assign any_low   = |low_valid;

  // Round-robin: lowest valid requester at or above rr_ptr; if none, wrap
  // around and take the lowest valid requester overall (bit 0 is masked off).
  always_comb begin
    rr_hi = '0;
    for (int k = 1; k < NUM_REQ; k++) begin
      rr_hi[k] = low_valid[k] && (k >= int'(rr_ptr));
    end
    rr_src  = (|rr_hi) ? rr_hi : low_valid;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      if (rr_src[k]) rr_pick = NUM_REQ'(1) << k;
    end
  end

  always_comb begin
    gnt = '0;
    if (!reset_n) begin
      gnt = '0;
    end else if (starve) begin
      gnt = rr_pick;
    end else if (bus.req_valid[0]) begin
      gnt = NUM_REQ'(1);
    end else begin
      gnt = rr_pick;
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx  = IDX_W'(k);
        gnt_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign gnt_low       = |gnt[NUM_REQ-1:1];
  assign bus.req_ready = gnt;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= IDX_W'(1);
      starve_cnt  <= '0;
      rom_addr_q  <= '0;
      tag_v       <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_idx[i] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      // frame_start wins over this edge's pointer/counter update; the grant
      // already made this cycle used the old pointer.
      if (frame_start) begin
        rr_ptr <= IDX_W'(1);
      end else if (gnt_low) begin
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
      end

      if (frame_start || gnt_low || !any_low) begin
        starve_cnt <= '0;
      end else if (gnt[0] && !starve) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      if (|gnt) rom_addr_q <= gnt_addr;

      // Tag pipeline matches ROM latency; idle cycles push bubbles.
      tag_v[0]   <= |gnt;
      tag_idx[0] <= gnt_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (tag_v[ROM_LAT-1]) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_idx[ROM_LAT-1];
        rsp_data_q  <= bus.rom_q;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_texture_rom_arbiter.sv
// tb/tb_texture_rom_arbiter.sv - directed self-checking bench for texture_rom_arbiter
module tb_texture_rom_arbiter;
  logic clk;
  logic rst_n;
  logic a_fs;
  logic b_fs;
  int   n_checks;
  int   n_fail;

  // dut_a: 3 requesters, ROM_LAT=1. dut_b: 4 requesters, ROM_LAT=3.
  texture_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8)) a_if ();
  texture_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) b_if ();

  texture_rom_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .ROM_LAT(1), .STARVE_MAX(15)) dut_a (
    .vga_clk(clk), .reset_n(rst_n), .frame_start(a_fs), .bus(a_if.slave)
  );
  texture_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .ROM_LAT(3), .STARVE_MAX(15)) dut_b (
    .vga_clk(clk), .reset_n(rst_n), .frame_start(b_fs), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: q = addr ^ 8'hFF, registered on the inverted clock, plus
  // extra posedge stages for the ROM_LAT=3 instance.
  logic [7:0] a_q, b_q0, b_q1, b_q2;
  always @(negedge clk) a_q <= a_if.rom_addr ^ 8'hFF;
  always @(negedge clk) b_q0 <= b_if.rom_addr ^ 8'hFF;
  always @(posedge clk) begin
    b_q1 <= b_q0;
    b_q2 <= b_q1;
  end
  assign a_if.rom_q = a_q;
  assign b_if.rom_q = b_q2;

  task automatic test_reset;
    rst_n = 1'b0;
    a_if.req_valid = 3'b011;
    b_if.req_valid = 4'b1111;
    a_if.req_addr = '0;
    b_if.req_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (a_if.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_a_ready: got %b want 000", a_if.req_ready); end
    n_checks++; if (b_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0000", b_if.req_ready); end
    n_checks++; if (a_if.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_a_rsp_valid: got %b want 000", a_if.rsp_valid); end
    n_checks++; if (b_if.rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_b_rom_addr: got %h want 00", b_if.rom_addr); end
    n_checks++; if (b_if.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_b_rsp_data: got %h want 00", b_if.rsp_data); end
    @(negedge clk);
    a_if.req_valid = '0;
    b_if.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (a_if.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL idle_a_rsp_valid: got %b want 000", a_if.rsp_valid); end
    n_checks++; if (b_if.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_b_rsp_valid: got %b want 0000", b_if.rsp_valid); end
  endtask

  task automatic test_single_read;
    @(negedge clk);
    a_if.req_valid = 3'b010;
    a_if.req_addr = {8'h00, 8'h2A, 8'h00};
    #1;
    n_checks++; if (a_if.req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", a_if.req_ready); end
    @(posedge clk);
    @(negedge clk);
    a_if.req_valid = 3'b000;
    n_checks++; if (a_if.rom_addr !== 8'h2A) begin n_fail++; $display("FAIL single_rom_addr: got %h want 2a", a_if.rom_addr); end
    n_checks++; if (a_if.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL single_rsp_early: got %b want 000", a_if.rsp_valid); end
    @(negedge clk);
    n_checks++; if (a_if.rsp_valid !== 3'b010) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 010", a_if.rsp_valid); end
    n_checks++; if (a_if.rsp_data !== 8'hD5) begin n_fail++; $display("FAIL single_rsp_data: got %h want d5", a_if.rsp_data); end
    @(negedge clk);
    n_checks++; if (a_if.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL single_rsp_after: got %b want 000", a_if.rsp_valid); end
    n_checks++; if (a_if.rsp_data !== 8'hD5) begin n_fail++; $display("FAIL single_rsp_hold: got %h want d5", a_if.rsp_data); end
  endtask

  task automatic test_round_robin;
    int seq [6] = '{1, 2, 3, 1, 2, 3};
    logic [3:0] ev;
    logic [7:0] ed;
    @(negedge clk);
    b_if.req_addr = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int c = 0; c < 9; c++) begin
      b_if.req_valid = (c < 6) ? 4'b1110 : 4'b0000;
      #1;
      if (c < 6) begin
        ev = 4'b0001 << seq[c];
        n_checks++; if (b_if.req_ready !== ev) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, b_if.req_ready, ev); end
      end
      @(posedge clk);
      @(negedge clk);
      ev = (c >= 3) ? (4'b0001 << seq[c-3]) : 4'b0000;
      n_checks++; if (b_if.rsp_valid !== ev) begin n_fail++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", c, b_if.rsp_valid, ev); end
      if (c >= 3) begin
        ed = 8'(17 * seq[c-3]) ^ 8'hFF;
        n_checks++; if (b_if.rsp_data !== ed) begin n_fail++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", c, b_if.rsp_data, ed); end
      end
    end
  endtask

  task automatic test_priority_starvation;
    int start, w, max_w, n2, g, gp;
    logic [2:0] ev;
    logic [7:0] ed;
    start = 0; max_w = 0; n2 = 0;
    @(negedge clk);
    a_if.req_addr = {8'h80, 8'h00, 8'h40};
    for (int c = 0; c < 33; c++) begin
      a_if.req_valid = (c < 32) ? 3'b101 : 3'b000;
      #1;
      if (c < 32) begin
        g  = ((c % 16) == 15) ? 2 : 0;
        ev = 3'b001 << g;
        n_checks++; if (a_if.req_ready !== ev) begin n_fail++; $display("FAIL prio_ready[%0d]: got %b want %b", c, a_if.req_ready, ev); end
        if (a_if.req_ready[2]) begin
          w = c - start + 1;
          if (w > max_w) max_w = w;
          start = c + 1;
          n2++;
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (c >= 1) begin
        gp = (((c - 1) % 16) == 15) ? 2 : 0;
        ev = 3'b001 << gp;
        ed = (gp == 2) ? 8'h7F : 8'hBF;
        n_checks++; if (a_if.rsp_valid !== ev) begin n_fail++; $display("FAIL prio_rsp_valid[%0d]: got %b want %b", c, a_if.rsp_valid, ev); end
        n_checks++; if (a_if.rsp_data !== ed) begin n_fail++; $display("FAIL prio_rsp_data[%0d]: got %h want %h", c, a_if.rsp_data, ed); end
      end
    end
    n_checks++; if (n2 !== 2) begin n_fail++; $display("FAIL prio_req2_grants: got %0d want 2", n2); end
    n_checks++; if (max_w > 16 || max_w < 1) begin n_fail++; $display("FAIL prio_req2_wait: got %0d want 1..16", max_w); end
  endtask

  task automatic test_frame_start;
    logic [3:0] vld [5] = '{4'b0100, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
    logic       fs  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int         gi  [5] = '{2, 3, 1, 2, 1};
    logic [3:0] ev;
    logic [7:0] ed;
    @(negedge clk);
    b_if.req_addr = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int c = 0; c < 8; c++) begin
      b_if.req_valid = (c < 5) ? vld[c] : 4'b0000;
      b_fs = (c < 5) ? fs[c] : 1'b0;
      #1;
      if (c < 5) begin
        ev = 4'b0001 << gi[c];
        n_checks++; if (b_if.req_ready !== ev) begin n_fail++; $display("FAIL fs_ready[%0d]: got %b want %b", c, b_if.req_ready, ev); end
      end
      @(posedge clk);
      @(negedge clk);
      b_fs = 1'b0;
      if (c >= 3) begin
        ev = 4'b0001 << gi[c-3];
        ed = 8'(17 * gi[c-3]) ^ 8'hFF;
        n_checks++; if (b_if.rsp_valid !== ev) begin n_fail++; $display("FAIL fs_rsp_valid[%0d]: got %b want %b", c, b_if.rsp_valid, ev); end
        n_checks++; if (b_if.rsp_data !== ed) begin n_fail++; $display("FAIL fs_rsp_data[%0d]: got %h want %h", c, b_if.rsp_data, ed); end
      end
    end
  endtask

  task automatic test_frame_start_starve;
    logic [2:0] ev;
    @(negedge clk);
    a_if.req_addr = {8'h80, 8'h00, 8'h40};
    for (int c = 0; c < 27; c++) begin
      a_if.req_valid = 3'b101;
      a_fs = (c == 10);
      #1;
      ev = (c == 26) ? 3'b100 : 3'b001;
      n_checks++; if (a_if.req_ready !== ev) begin n_fail++; $display("FAIL fs_starve_ready[%0d]: got %b want %b", c, a_if.req_ready, ev); end
      @(posedge clk);
      @(negedge clk);
      a_fs = 1'b0;
    end
    a_if.req_valid = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int         seq  [5] = '{0, 1, 0, 2, 0};
    logic [7:0] addr [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    logic [3:0] ev;
    logic [7:0] ed;
    @(negedge clk);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        b_if.req_valid = 4'b0001 << seq[c];
        b_if.req_addr  = 32'(addr[c]) << (8 * seq[c]);
      end else begin
        b_if.req_valid = 4'b0000;
      end
      #1;
      if (c < 5) begin
        ev = 4'b0001 << seq[c];
        n_checks++; if (b_if.req_ready !== ev) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, b_if.req_ready, ev); end
      end
      @(posedge clk);
      @(negedge clk);
      ev = (c >= 3 && c < 8) ? (4'b0001 << seq[c-3]) : 4'b0000;
      n_checks++; if (b_if.rsp_valid !== ev) begin n_fail++; $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", c, b_if.rsp_valid, ev); end
      if (c >= 3 && c < 8) begin
        ed = addr[c-3] ^ 8'hFF;
        n_checks++; if (b_if.rsp_data !== ed) begin n_fail++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", c, b_if.rsp_data, ed); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    b_if.req_valid = 4'b0010;
    b_if.req_addr  = {8'h00, 8'h6B, 8'h5A, 8'h00};
    @(posedge clk);
    @(negedge clk);
    b_if.req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    b_if.req_valid = 4'b0010;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (b_if.rom_addr !== 8'h00) begin n_fail++; $display("FAIL midreset_rom_addr: got %h want 00", b_if.rom_addr); end
    n_checks++; if (b_if.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midreset_rsp_valid: got %b want 0000", b_if.rsp_valid); end
    n_checks++; if (b_if.rsp_data !== 8'h00) begin n_fail++; $display("FAIL midreset_rsp_data: got %h want 00", b_if.rsp_data); end
    n_checks++; if (b_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_ready: got %b want 0000", b_if.req_ready); end
    n_checks++; if (a_if.rsp_data !== 8'h00) begin n_fail++; $display("FAIL midreset_a_rsp_data: got %h want 00", a_if.rsp_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_if.req_valid = 4'b0000;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (b_if.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL postreset_rsp_valid[%0d]: got %b want 0000", c, b_if.rsp_valid); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    a_fs     = 1'b0;
    b_fs     = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority_starvation();
    test_frame_start();
    test_frame_start_starve();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
